// File: rtl/game_pkg.sv
// Shared constants and types for the dice game input conditioning.
package game_pkg;

    localparam logic [1:0] MODE_BLANK = 2'd0;
    localparam logic [1:0] MODE_1     = 2'd1;
    localparam logic [1:0] MODE_2     = 2'd2;
    localparam logic [1:0] MODE_3     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } play_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for one raw push-button.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          lvl_reg;
    logic          rise_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            lvl_reg   <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            // Any sample that agrees with the accepted level restarts the count.
            if (sync2_reg != lvl_reg) begin
                if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
                    lvl_reg  <= ~lvl_reg;
                    rise_reg <= ~lvl_reg;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign lvl  = lvl_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/game_input_ctrl.sv
// Debounced play strobe with auto-repeat and mode stepping for the dice game core.
module game_input_ctrl
    import game_pkg::*;
#(
    parameter int DEB_CYCLES    = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_play,
    input  logic       btn_mode,
    output logic       in,
    output logic [1:0] sel,
    output logic       play_level
);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX);

    logic [1:0] raw_vec;
    logic [1:0] lvl_vec;
    logic [1:0] rise_vec;

    assign raw_vec = {btn_mode, btn_play};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk (clk),
                .rst (rst),
                .raw (raw_vec[gi]),
                .lvl (lvl_vec[gi]),
                .rise(rise_vec[gi])
            );
        end
    endgenerate

    logic        play_lvl;
    logic        play_rise;
    logic        mode_rise;

    assign play_lvl  = lvl_vec[0];
    assign play_rise = rise_vec[0];
    // A rise is always reported together with the new high level.
    assign mode_rise = rise_vec[1] & lvl_vec[1];

    play_state_t   state_reg;
    logic [TW-1:0] tcnt_reg;
    logic          in_reg;
    logic [1:0]    sel_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            tcnt_reg  <= '0;
            in_reg    <= 1'b0;
            sel_reg   <= MODE_BLANK;
        end else begin
            in_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tcnt_reg <= '0;
                    // Play wins a same-cycle tie; the mode edge is simply lost.
                    if (play_rise) begin
                        in_reg    <= 1'b1;
                        state_reg <= ST_HELD;
                    end else if (mode_rise) begin
                        sel_reg <= sel_reg + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (!play_lvl) begin
                        state_reg <= ST_IDLE;
                        tcnt_reg  <= '0;
                    end else if (tcnt_reg == TW'(HOLD_CYCLES - 1)) begin
                        in_reg    <= 1'b1;
                        tcnt_reg  <= '0;
                        state_reg <= ST_REPEAT;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!play_lvl) begin
                        state_reg <= ST_IDLE;
                        tcnt_reg  <= '0;
                    end else if (tcnt_reg == TW'(REPEAT_CYCLES - 1)) begin
                        in_reg   <= 1'b1;
                        tcnt_reg <= '0;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tcnt_reg  <= '0;
                end
            endcase
        end
    end

    assign in         = in_reg;
    assign sel        = sel_reg;
    assign play_level = play_lvl;

endmodule
